// File: rtl/snake_uart_tx.sv
// snake_uart_tx: 8N1 UART transmitter fed by a small FIFO.
// Bytes are queued over a valid/ready push port and sent LSB first.
module snake_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] TxData,
  input  logic       TxValid,
  output logic       TxReady,
  output logic       UartTxWire,
  output logic       Busy,
  output logic [2:0] FifoCount
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] LAST =
    16'(CLKS_PER_BIT - 1);
  localparam logic [2:0] FULL =
    3'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t         state;
  logic [15:0]    baud_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [2:0]     count;

  logic           full;
  logic           push;
  logic           pop;
  logic           bit_end;
  logic [7:0]     head;

  assign full      = (count == FULL);
  assign TxReady   = !full;
  assign FifoCount = count;
  assign push      = TxValid && !full;
  assign bit_end   = (baud_cnt == LAST);
  assign head      = mem[rd_ptr];

  // Dequeue when idle, or on the last stop cycle to chain frames.
  assign pop = (count != 3'd0) &&
               ((state == IDLE) ||
                ((state == STOP) && bit_end));

  // FIFO pointers and occupancy; push+pop leaves count unchanged.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; data is captured at the accepting edge.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= TxData;
    end
  end

  // Frame sequencer with registered line and busy outputs.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      UartTxWire <= 1'b1;
      Busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (pop) begin
            shreg      <= head;
            state      <= START;
            UartTxWire <= 1'b0;
            Busy       <= 1'b1;
          end else begin
            UartTxWire <= 1'b1;
            Busy       <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt   <= '0;
            bit_idx    <= '0;
            state      <= DATA;
            UartTxWire <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state      <= STOP;
              UartTxWire <= 1'b1;
            end else begin
              bit_idx    <= bit_idx + 3'd1;
              shreg      <= shreg >> 1;
              UartTxWire <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            if (pop) begin
              shreg      <= head;
              state      <= START;
              UartTxWire <= 1'b0;
              Busy       <= 1'b1;
            end else begin
              state      <= IDLE;
              UartTxWire <= 1'b1;
              Busy       <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          state      <= IDLE;
          UartTxWire <= 1'b1;
          Busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_uart_tx.sv
// tb_snake_uart_tx: scoreboard bench for snake_uart_tx.
// A line monitor decodes frames and checks them against pushed bytes.
module tb_snake_uart_tx;

  localparam int CPB = 4;

  logic       Clk;
  logic       Rst;
  logic [7:0] TxData;
  logic       TxValid;
  logic       TxReady;
  logic       UartTxWire;
  logic       Busy;
  logic [2:0] FifoCount;

  snake_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .TxData    (TxData),
    .TxValid   (TxValid),
    .TxReady   (TxReady),
    .UartTxWire(UartTxWire),
    .Busy      (Busy),
    .FifoCount (FifoCount)
  );

  int         n_chk;
  int         n_fail;
  int         cyc;
  int         busy_cyc;
  logic [7:0] sb[$];
  int         starts[$];
  logic       mon_active;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    busy_cyc = 0;
    forever begin
      @(posedge Clk);
      #2;
      if (Busy === 1'b1)
        busy_cyc++;
    end
  end

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  initial begin
    int         mcnt;
    logic [7:0] mbyte;
    logic [7:0] exp;
    mon_active = 1'b0;
    mcnt = 0;
    mbyte = '0;
    forever begin
      @(negedge Clk);
      if (Rst !== 1'b1) begin
        mon_active = 1'b0;
      end else if (!mon_active) begin
        if (UartTxWire === 1'b0) begin
          mon_active = 1'b1;
          mcnt = 0;
          starts.push_back(cyc);
        end
      end else begin
        mcnt++;
        if (mcnt == 2)
          chk("start_bit", int'(UartTxWire), 0);
        if (mcnt >= 5 && mcnt <= 33 &&
            ((mcnt - 5) % 4) == 0)
          mbyte = {UartTxWire, mbyte[7:1]};
        if (mcnt == 37) begin
          chk("stop_bit", int'(UartTxWire), 1);
          chk("frame_expected",
              int'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            exp = sb.pop_front();
            chk("rx_byte", int'(mbyte), int'(exp));
          end
        end
        if (mcnt == 39)
          mon_active = 1'b0;
      end
    end
  end

  // Called at a negedge; byte is offered to the next posedge.
  task automatic push(input logic [7:0] d,
                      input logic acc);
    TxData  = d;
    TxValid = 1'b1;
    chk("tx_ready", int'(TxReady), int'(acc));
    if (acc)
      sb.push_back(d);
    @(negedge Clk);
    TxValid = 1'b0;
    TxData  = 8'($urandom);
  endtask

  task automatic wait_done(input int max);
    int ok;
    ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge Clk);
      if (Busy === 1'b0 && sb.size() == 0 &&
          !mon_active) begin
        ok = 1;
        break;
      end
    end
    chk("drain_timeout", ok, 1);
  endtask

  initial begin
    int bad;
    n_chk   = 0;
    n_fail  = 0;
    cyc     = 0;
    Rst     = 1'b0;
    TxData  = '0;
    TxValid = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_line", int'(UartTxWire), 1);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_count", int'(FifoCount), 0);
    chk("rst_ready", int'(TxReady), 1);
    Rst = 1'b1;

    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge Clk);
      if (UartTxWire !== 1'b1 || Busy !== 1'b0 ||
          TxReady !== 1'b1)
        bad++;
    end
    chk("idle_hold", bad, 0);

    busy_cyc = 0;
    push(8'hA5, 1'b1);
    chk("lat_pre", int'(UartTxWire), 1);
    @(negedge Clk);
    chk("lat_start", int'(UartTxWire), 0);
    chk("lat_busy", int'(Busy), 1);
    repeat (3) @(negedge Clk);
    chk("start_len", int'(UartTxWire), 0);
    @(negedge Clk);
    chk("a5_bit0", int'(UartTxWire), 1);
    repeat (4) @(negedge Clk);
    chk("a5_bit1", int'(UartTxWire), 0);
    wait_done(100);
    chk("a5_busy_cyc", busy_cyc, 40);

    busy_cyc = 0;
    starts.delete();
    push(8'h00, 1'b1);
    push(8'hFF, 1'b1);
    wait_done(200);
    chk("b2b_busy_cyc", busy_cyc, 80);
    chk("b2b_count", int'(FifoCount), 0);
    chk("b2b_frames", starts.size(), 2);
    if (starts.size() == 2)
      chk("b2b_gap", starts[1] - starts[0], 40);

    for (int i = 1; i <= 6; i++)
      push(8'(i), i <= 5 ? 1'b1 : 1'b0);
    chk("full_count", int'(FifoCount), 4);
    chk("full_ready", int'(TxReady), 0);
    wait_done(400);
    chk("full_drain", int'(FifoCount), 0);

    push(8'h11, 1'b1);
    push(8'h22, 1'b1);
    push(8'h33, 1'b1);
    repeat (38) @(negedge Clk);
    chk("pp_count_pre", int'(FifoCount), 2);
    chk("pp_busy", int'(Busy), 1);
    push(8'h44, 1'b1);
    chk("pp_count_post", int'(FifoCount), 2);
    chk("pp_restart", int'(UartTxWire), 0);
    wait_done(300);

    push(8'h3C, 1'b1);
    push(8'hAA, 1'b1);
    push(8'hBB, 1'b1);
    repeat (16) @(negedge Clk);
    chk("mid_count", int'(FifoCount), 2);
    chk("mid_busy", int'(Busy), 1);
    sb.delete();
    Rst = 1'b0;
    #1;
    chk("abort_line", int'(UartTxWire), 1);
    chk("abort_busy", int'(Busy), 0);
    chk("abort_count", int'(FifoCount), 0);
    chk("abort_ready", int'(TxReady), 1);
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (UartTxWire !== 1'b1 || Busy !== 1'b0)
        bad++;
    end
    chk("post_rst_quiet", bad, 0);
    busy_cyc = 0;
    push(8'h5A, 1'b1);
    chk("rel_pre", int'(UartTxWire), 1);
    @(negedge Clk);
    chk("rel_start", int'(UartTxWire), 0);
    wait_done(100);
    chk("rel_busy_cyc", busy_cyc, 40);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_uart_tx.md
SNAKE_UART_TX -- requirements
Module: snake_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, Clk cycles per UART bit (115200 baud at 50 MHz); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, transmit FIFO entries; fixed at 4 for this revision.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 TxData  input  8  byte to queue for transmission.
REQ-006 TxValid  input  1  producer offers TxData this cycle.
REQ-007 TxReady  output  1  FIFO can accept a byte this cycle.
REQ-008 UartTxWire  output  1  serial line, idle high, 8N1.
REQ-009 Busy  output  1  a frame is on the line (start, data or stop bit).
REQ-010 FifoCount  output  3  bytes queued and not yet started, 0..4.

Function
REQ-011 Push handshake SHALL be: byte accepted at the rising edge where TxValid=1 and TxReady=1; TxData ignored otherwise.
REQ-012 TxReady SHALL be 1 iff registered FifoCount<4; a push offered while full is dropped even if a pop occurs that cycle.
REQ-013 FIFO SHALL be first-in first-out, pointers wrap modulo 4; push and pop in the same cycle leave FifoCount unchanged.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-015 IDLE: UartTxWire=1; if FifoCount>0, pop head into shift register, reset baud counter, go to START at that edge.
REQ-016 START: UartTxWire=0 for exactly CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-017 DATA: UartTxWire=shift bit, LSB first, each bit CLKS_PER_BIT cycles; after bit 7 go to STOP.
REQ-018 STOP: UartTxWire=1 for exactly CLKS_PER_BIT cycles; at its last cycle, if FifoCount>0 pop and go directly to START (no idle gap), else go to IDLE.
REQ-019 Latency: byte pushed into empty FIFO with FSM in IDLE at edge k SHALL drive start bit from edge k+1; full frame is 10*CLKS_PER_BIT cycles.
REQ-020 Baud counter width SHALL be 16 bits; counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
REQ-021 UartTxWire SHALL be a registered output (no combinational glitches).
REQ-022 Busy SHALL be 1 in START, DATA, STOP; 0 in IDLE.
REQ-023 TxData changes after acceptance SHALL not affect queued or in-flight bytes.

Reset
REQ-024 Rst=0 SHALL immediately force: state IDLE, UartTxWire=1, Busy=0, FifoCount=0, TxReady=1, FIFO pointers and counters 0.
REQ-025 Reset mid-frame SHALL abort the frame immediately (line high) and discard all queued bytes; no partial frame resumes after release.
REQ-026 After Rst returns to 1, the first push SHALL behave per REQ-019.

Verification (CLKS_PER_BIT=4)
REQ-027 Single byte: push 0xA5 into idle block at edge k -> line low edges k+1..k+4, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop high 4 cycles; Busy high exactly 40 cycles.
REQ-028 Back-to-back: push 0x00, 0xFF on consecutive cycles -> two frames, second start bit begins the cycle after first stop bit ends, total 80 Busy cycles, FifoCount 0 at end.
REQ-029 Full FIFO: push 6 bytes 0x01..0x06 on consecutive cycles while idle -> 0x01 popped immediately, 0x02..0x05 queued (FifoCount=4, TxReady=0), 0x06 dropped; line carries 0x01..0x05 in order.
REQ-030 Simultaneous push/pop: with FifoCount=2, push on the STOP-to-START edge -> FifoCount stays 2, data order preserved.
REQ-031 Reset mid-frame: assert Rst=0 during DATA bit 3 of 0x3C with 2 bytes queued -> line high same cycle, FifoCount=0, Busy=0; after release line stays high until a new push.
REQ-032 Idle hold: no pushes for 1000 cycles after reset -> UartTxWire=1, Busy=0, TxReady=1 throughout.
